// File: rtl/ir_cam_pkg.sv
// rtl/ir_cam_pkg.sv - shared types and constants for the IR camera report path
package ir_cam_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_XLO,
    ST_YLO,
    ST_SB,
    ST_SKIP,
    ST_DONE
  } ir_state_e;

  localparam int IR_FRAME_BYTES = 16;
  localparam logic [7:0] IR_NO_BLOB = 8'hFF;

  // S byte layout: Y[9:8] | X[9:8] | size
  localparam int SB_Y_MSB    = 7;
  localparam int SB_Y_LSB    = 6;
  localparam int SB_X_MSB    = 5;
  localparam int SB_X_LSB    = 4;
  localparam int SB_SIZE_MSB = 3;
  localparam int SB_SIZE_LSB = 0;

endpackage

// File: rtl/timeout_counter.sv
// rtl/timeout_counter.sv - idle-cycle counter with a terminal pulse at LIMIT-1
module timeout_counter #(
  parameter int LIMIT = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count;

  assign expired = enable && !clear && (count == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || !enable || expired) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ir_blob_decoder.sv
// rtl/ir_blob_decoder.sv - extracts blob 0 position and size from an IR camera report frame
module ir_blob_decoder
  import ir_cam_pkg::*;
#(
  parameter int FRAME_BYTES = IR_FRAME_BYTES,
  parameter int TIMEOUT     = 100000,
  parameter int RESET_X     = 500,
  parameter int RESET_Y     = 500,
  parameter int Y_MAX       = 767
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic [3:0]  size,
  output logic        blob_present,
  output logic        xy_valid,
  output logic        frame_err
);

  localparam int BW = $clog2(FRAME_BYTES);
  localparam logic [BW-1:0] LAST_BYTE = BW'(FRAME_BYTES - 1);
  localparam logic [10:0] Y_LIMIT = 11'(Y_MAX);

  ir_state_e     state;
  logic [BW-1:0] byte_cnt;
  logic [7:0]    x_lo;
  logic [7:0]    y_lo;
  logic [7:0]    s_byte;
  logic          busy;
  logic          timeout_hit;
  logic [9:0]    y_full;
  logic          absent;

  assign busy   = (state != ST_IDLE) && (state != ST_DONE);
  assign y_full = {s_byte[SB_Y_MSB:SB_Y_LSB], y_lo};
  assign absent = ((x_lo == IR_NO_BLOB) && (y_lo == IR_NO_BLOB) && (s_byte == IR_NO_BLOB))
                  || ({1'b0, y_full} > Y_LIMIT);

  timeout_counter #(
    .LIMIT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (byte_valid || frame_start),
    .enable (busy),
    .expired(timeout_hit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      byte_cnt     <= '0;
      x_lo         <= IR_NO_BLOB;
      y_lo         <= IR_NO_BLOB;
      s_byte       <= IR_NO_BLOB;
      x            <= 11'(RESET_X);
      y            <= 11'(RESET_Y);
      size         <= '0;
      blob_present <= 1'b0;
      xy_valid     <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      xy_valid  <= 1'b0;
      frame_err <= 1'b0;

      // Commit happens in DONE even if a new frame starts in the same cycle
      if (state == ST_DONE) begin
        if (absent) begin
          blob_present <= 1'b0;
        end else begin
          x            <= {1'b0, s_byte[SB_X_MSB:SB_X_LSB], x_lo};
          y            <= {1'b0, y_full};
          size         <= s_byte[SB_SIZE_MSB:SB_SIZE_LSB];
          blob_present <= 1'b1;
          xy_valid     <= 1'b1;
        end
      end

      if (frame_start) begin
        frame_err <= busy;
        state     <= ST_HDR;
        byte_cnt  <= '0;
        x_lo      <= IR_NO_BLOB;
        y_lo      <= IR_NO_BLOB;
        s_byte    <= IR_NO_BLOB;
      end else if (timeout_hit) begin
        frame_err <= 1'b1;
        state     <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: ;
          ST_HDR: if (byte_valid) begin
            byte_cnt <= byte_cnt + 1'b1;
            state    <= ST_XLO;
          end
          ST_XLO: if (byte_valid) begin
            x_lo     <= byte_in;
            byte_cnt <= byte_cnt + 1'b1;
            state    <= ST_YLO;
          end
          ST_YLO: if (byte_valid) begin
            y_lo     <= byte_in;
            byte_cnt <= byte_cnt + 1'b1;
            state    <= ST_SB;
          end
          ST_SB: if (byte_valid) begin
            s_byte   <= byte_in;
            byte_cnt <= byte_cnt + 1'b1;
            state    <= ST_SKIP;
          end
          ST_SKIP: if (byte_valid) begin
            if (byte_cnt == LAST_BYTE) begin
              state <= ST_DONE;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ir_blob_decoder.sv
// tb/tb_ir_blob_decoder.sv - scoreboard bench for ir_blob_decoder
module tb_ir_blob_decoder;

  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic [10:0] x;
  logic [10:0] y;
  logic [3:0]  size;
  logic        blob_present;
  logic        xy_valid;
  logic        frame_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    bit          is_err;
    int          cyc_lo;
    int          cyc_hi;
    logic [10:0] ex;
    logic [10:0] ey;
    logic [3:0]  esize;
  } exp_t;

  exp_t q[$];

  ir_blob_decoder #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .x           (x),
    .y           (y),
    .size        (size),
    .blob_present(blob_present),
    .xy_valid    (xy_valid),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every output pulse must match the oldest queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (!reset && (xy_valid || frame_err)) begin
      checks++;
      if (xy_valid && frame_err) begin
        errors++;
        $display("FAIL pulse_overlap: xy_valid and frame_err both high at cycle %0d", cyc);
      end else if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: xy_valid=%0d frame_err=%0d at cycle %0d, nothing expected",
                 xy_valid, frame_err, cyc);
      end else begin
        e = q.pop_front();
        if (e.is_err != frame_err || cyc < e.cyc_lo || cyc > e.cyc_hi) begin
          errors++;
          $display("FAIL pulse_kind_time: got frame_err=%0d at cycle %0d expected frame_err=%0d in cycles %0d..%0d",
                   frame_err, cyc, e.is_err, e.cyc_lo, e.cyc_hi);
        end else if (xy_valid) begin
          check("xy_x", int'(x), int'(e.ex));
          check("xy_y", int'(y), int'(e.ey));
          check("xy_size", int'(size), int'(e.esize));
          check("xy_present", int'(blob_present), 1);
        end
      end
    end
  end

  task automatic push_exp(input bit is_err, input int lo, input int hi,
                          input int ex, input int ey, input int es);
    exp_t e;
    e.is_err = is_err;
    e.cyc_lo = lo;
    e.cyc_hi = hi;
    e.ex     = 11'(ex);
    e.ey     = 11'(ey);
    e.esize  = 4'(es);
    q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends frame_start then nbytes bytes (header 0x00, blob 0 bytes, then 0xFF filler)
  task automatic run_frame(input logic [7:0] xl, input logic [7:0] yl, input logic [7:0] sb,
                           input int nbytes, input bit exp_err, input bit exp_xy,
                           input int ex, input int ey, input int es, output int last_c);
    logic [7:0] b;
    if (exp_err) push_exp(1'b1, cyc + 1, cyc + 1, 0, 0, 0);
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    for (int i = 0; i < nbytes; i++) begin
      case (i)
        0:       b = 8'h00;
        1:       b = xl;
        2:       b = yl;
        3:       b = sb;
        default: b = 8'hFF;
      endcase
      if (i == nbytes - 1) begin
        last_c = cyc;
        if (exp_xy) push_exp(1'b0, cyc + 2, cyc + 2, ex, ey, es);
      end
      send_byte(b);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "global timeout");
  end

  initial begin
    int lc;
    int wait_c;
    idle(3);
    check("rst_x", int'(x), 500);
    check("rst_y", int'(y), 500);
    check("rst_size", int'(size), 0);
    check("rst_present", int'(blob_present), 0);
    check("rst_xy_valid", int'(xy_valid), 0);
    check("rst_frame_err", int'(frame_err), 0);
    reset = 1'b0;
    idle(2);

    // Basic valid frame
    run_frame(8'hA5, 8'h3C, 8'h63, 16, 0, 1, 677, 316, 3, lc);
    idle(4);

    // All-0xFF blob: absent, outputs hold
    run_frame(8'hFF, 8'hFF, 8'hFF, 16, 0, 0, 0, 0, 0, lc);
    idle(4);
    check("absent_x", int'(x), 677);
    check("absent_y", int'(y), 316);
    check("absent_present", int'(blob_present), 0);

    // Y = 0x3FF exceeds Y_MAX
    run_frame(8'h10, 8'hFF, 8'hC0, 16, 0, 0, 0, 0, 0, lc);
    idle(4);
    check("ybig_x", int'(x), 677);
    check("ybig_y", int'(y), 316);
    check("ybig_present", int'(blob_present), 0);

    // Y = 767 is legal, Y = 768 is not
    run_frame(8'h00, 8'hFF, 8'h80, 16, 0, 1, 0, 767, 0, lc);
    idle(3);
    run_frame(8'h00, 8'h00, 8'hC0, 16, 0, 0, 0, 0, 0, lc);
    idle(4);
    check("y768_y", int'(y), 767);
    check("y768_present", int'(blob_present), 0);

    // Abort after 5 bytes, then a full frame X=100 Y=200 size=5
    run_frame(8'h11, 8'h22, 8'h33, 5, 0, 0, 0, 0, 0, lc);
    run_frame(8'h64, 8'hC8, 8'h05, 16, 1, 1, 100, 200, 5, lc);
    idle(4);

    // Stall after 7 bytes until timeout, then stray bytes without frame_start
    run_frame(8'h01, 8'h01, 8'h00, 7, 0, 0, 0, 0, 0, lc);
    push_exp(1'b1, lc + TO, lc + TO + 2, 0, 0, 0);
    idle(TO + 5);
    for (int i = 0; i < 9; i++) send_byte(8'h00);
    idle(4);
    check("to_x", int'(x), 100);
    check("to_y", int'(y), 200);
    check("to_present", int'(blob_present), 1);

    // Async reset mid-SKIP
    run_frame(8'h55, 8'h44, 8'h00, 8, 0, 0, 0, 0, 0, lc);
    reset = 1'b1;
    #1;
    check("arst_x", int'(x), 500);
    check("arst_y", int'(y), 500);
    check("arst_present", int'(blob_present), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(2);
    run_frame(8'h34, 8'h12, 8'h9A, 16, 0, 1, 308, 530, 10, lc);

    // Back-to-back: second frame_start lands in the DONE cycle
    run_frame(8'h01, 8'h02, 8'h00, 16, 0, 1, 1, 2, 0, lc);
    run_frame(8'hFF, 8'h00, 8'h2F, 16, 0, 1, 767, 0, 15, lc);

    wait_c = 0;
    while (q.size() != 0 && wait_c < 60) begin
      idle(1);
      wait_c++;
    end
    idle(4);
    check("scoreboard_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
